// File: rtl/hist_bin_update_if.sv
// Sample stream and histogram-RAM port bundle for hist_bin_update.
interface hist_bin_update_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_bin;
    logic              in_ready;
    logic [ADDR_W-1:0] ram_rdaddress;
    logic [ADDR_W-1:0] ram_wraddress;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  in_valid, in_bin, ram_q,
        output in_ready, ram_rdaddress, ram_wraddress, ram_data, ram_wren
    );

    modport master (
        output in_valid, in_bin, ram_q,
        input  in_ready, ram_rdaddress, ram_wraddress, ram_data, ram_wren
    );
endinterface

// File: rtl/hist_bin_update.sv
// Pipelined read-modify-write histogram bin incrementer with write forwarding,
// zero-sweep of the RAM after reset / on request, and saturating statistics.
module hist_bin_update #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_req,
    hist_bin_update_if.slave  bus,
    output logic              busy,
    output logic [DATA_W-1:0] sample_count,
    output logic              sat_flag
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {CLEAR, RUN, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W:0]   clr_cnt;
    logic              sw_wren;
    logic [ADDR_W-1:0] sw_addr;

    logic              stg_v   [RD_LAT];
    logic [ADDR_W-1:0] stg_bin [RD_LAT];
    logic              fb_v    [RD_LAT];
    logic [ADDR_W-1:0] fb_a    [RD_LAT];
    logic [DATA_W-1:0] fb_d    [RD_LAT];

    logic              accept;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_bin;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] wb_data;
    logic              wb_sat;
    logic              pipe_busy;
    logic              drain_done;
    logic              hit;

    assign accept     = bus.in_valid && bus.in_ready;
    assign wb_valid   = stg_v[RD_LAT-1];
    assign wb_bin     = stg_bin[RD_LAT-1];
    assign drain_done = (state == DRAIN) && !pipe_busy;

    // Index 0 is the newest write; the first match wins over older entries and ram_q.
    always_comb begin
        base = bus.ram_q;
        hit  = 1'b0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            if (!hit && fb_v[i] && (fb_a[i] == wb_bin)) begin
                base = fb_d[i];
                hit  = 1'b1;
            end
        end
    end

    assign wb_sat  = &base;
    assign wb_data = wb_sat ? base : base + DATA_W'(1);

    // Stage RD_LAT-1 commits on this edge, so only earlier stages hold DRAIN.
    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
            pipe_busy = pipe_busy | stg_v[i];
        end
    end

    assign bus.in_ready      = (state == RUN);
    assign busy              = (state != RUN);
    assign bus.ram_rdaddress = bus.in_bin;
    assign bus.ram_wren      = sw_wren | wb_valid;
    assign bus.ram_wraddress = sw_wren ? sw_addr : (wb_valid ? wb_bin : '0);
    assign bus.ram_data      = (wb_valid && !sw_wren) ? wb_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            sw_wren      <= 1'b0;
            sw_addr      <= '0;
            sample_count <= '0;
            sat_flag     <= 1'b0;
        end else begin
            if (wb_valid && wb_sat) begin
                sat_flag <= 1'b1;
            end
            case (state)
                CLEAR: begin
                    if (clr_cnt == (ADDR_W+1)'(DEPTH)) begin
                        sw_wren <= 1'b0;
                        state   <= RUN;
                    end else begin
                        sw_wren <= 1'b1;
                        sw_addr <= clr_cnt[ADDR_W-1:0];
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (accept && !(&sample_count)) begin
                        sample_count <= sample_count + 1'b1;
                    end
                    if (clear_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        state        <= CLEAR;
                        clr_cnt      <= '0;
                        sample_count <= '0;
                        sat_flag     <= 1'b0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                stg_v[i]   <= 1'b0;
                stg_bin[i] <= '0;
                fb_v[i]    <= 1'b0;
                fb_a[i]    <= '0;
                fb_d[i]    <= '0;
            end
        end else begin
            stg_v[0]   <= accept;
            stg_bin[0] <= bus.in_bin;
            fb_v[0]    <= wb_valid && !drain_done;
            fb_a[0]    <= wb_bin;
            fb_d[0]    <= wb_data;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                stg_v[i]   <= stg_v[i-1];
                stg_bin[i] <= stg_bin[i-1];
                fb_v[i]    <= fb_v[i-1] && !drain_done;
                fb_a[i]    <= fb_a[i-1];
                fb_d[i]    <= fb_d[i-1];
            end
        end
    end
endmodule

// File: tb/tb_hist_bin_update.sv
// Scoreboard bench for hist_bin_update with a behavioural RD_LAT=2 RAM model.
module tb_hist_bin_update;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear_req = 1'b0;
    logic              busy;
    logic [DATA_W-1:0] sample_count;
    logic              sat_flag;

    hist_bin_update_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    hist_bin_update #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_req    (clear_req),
        .bus          (bus),
        .busy         (busy),
        .sample_count (sample_count),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    // RAM: address registered at the accept edge, q one edge later, old data on collision.
    logic [DATA_W-1:0] mem [32];
    logic [ADDR_W-1:0] rd_addr_r = '0;
    logic [DATA_W-1:0] q_r = '0;
    logic              preload_en = 1'b0;
    logic [ADDR_W-1:0] preload_addr = '0;
    logic [DATA_W-1:0] preload_data = '0;

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
        if (preload_en) mem[preload_addr] <= preload_data;
        rd_addr_r <= bus.ram_rdaddress;
        q_r       <= mem[rd_addr_r];
    end
    assign bus.ram_q = q_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                c;
    } wr_t;
    wr_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.ram_wren) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, no write expected",
                             bus.ram_wraddress, bus.ram_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bus.ram_wraddress), 64'(e.a));
                    chk("wr_data", 64'(bus.ram_data), 64'(e.d));
                    if (e.c >= 0) chk("wr_cycle", 64'(cyc), 64'(e.c));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 32; i++) exp_q.push_back('{a: ADDR_W'(i), d: '0, c: -1});
    endtask

    task automatic wait_ready(string name);
        int n = 0;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        chk({name, "_ready"}, 64'(bus.in_ready), 64'd1);
        chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Caller guarantees in_ready is high; the write shows two cycles after drive.
    task automatic send(int bin, logic [DATA_W-1:0] exp);
        bus.in_valid = 1'b1;
        bus.in_bin   = ADDR_W'(bin);
        exp_q.push_back('{a: ADDR_W'(bin), d: exp, c: cyc + 2});
        tick();
    endtask

    task automatic idle(int n);
        bus.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_clear(string name);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push_sweep();
        wait_ready(name);
    endtask

    task automatic check_reset_values(string name);
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        chk({name, "_wren"}, 64'(bus.ram_wren), 64'd0);
        chk({name, "_wraddr"}, 64'(bus.ram_wraddress), 64'd0);
        chk({name, "_wdata"}, 64'(bus.ram_data), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        chk({name, "_count"}, 64'(sample_count), 64'd0);
        chk({name, "_sat"}, 64'(sat_flag), 64'd0);
    endtask

    initial begin : stimulus
        logic [DATA_W-1:0] exp_stream [10];
        int low_cycles;
        int nonzero;
        exp_stream = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
        bus.in_valid = 1'b0;
        bus.in_bin   = '0;

        repeat (3) tick();
        check_reset_values("reset");

        push_sweep();
        rst_n = 1'b1;
        wait_ready("boot");
        chk("boot_busy", 64'(busy), 64'd0);
        chk("boot_count", 64'(sample_count), 64'd0);

        send(3, 1);
        idle(6);
        chk("single_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("single_count", 64'(sample_count), 64'd1);

        do_clear("clr1");
        send(7, 1); send(7, 2); send(7, 3); send(7, 4);
        idle(5);
        chk("same_bin_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("same_bin_count", 64'(sample_count), 64'd4);

        do_clear("clr2");
        send(1, 1); send(2, 1); send(1, 2); send(2, 2);
        idle(5);
        chk("alt_bin_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("alt_bin_count", 64'(sample_count), 64'd4);

        do_clear("clr3");
        preload_en   = 1'b1;
        preload_addr = 5'd5;
        preload_data = 32'hFFFF_FFFE;
        tick();
        preload_en = 1'b0;
        tick();
        chk("pre_sat_flag", 64'(sat_flag), 64'd0);
        send(5, 32'hFFFF_FFFF);
        send(5, 32'hFFFF_FFFF);
        idle(5);
        chk("sat_flag_set", 64'(sat_flag), 64'd1);
        chk("sat_count", 64'(sample_count), 64'd2);

        // Tenth sample carries clear_req; its write must precede the sweep.
        for (int i = 0; i < 10; i++) begin
            clear_req = (i == 9);
            send(i % 4, exp_stream[i]);
        end
        clear_req    = 1'b0;
        bus.in_valid = 1'b0;
        push_sweep();
        low_cycles = 1;
        while (!bus.in_ready && low_cycles < 300) begin
            tick();
            if (!bus.in_ready) low_cycles++;
        end
        chk("clear_low_ge_33", 64'(low_cycles >= 33), 64'd1);
        chk("clear_ready", 64'(bus.in_ready), 64'd1);
        chk("clear_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("clear_count", 64'(sample_count), 64'd0);
        chk("clear_sat", 64'(sat_flag), 64'd0);
        nonzero = 0;
        for (int i = 0; i < 32; i++) if (mem[i] != '0) nonzero++;
        chk("clear_bins_zero", 64'(nonzero), 64'd0);

        // Two bin-9 samples in flight when reset hits: neither may be written.
        bus.in_valid = 1'b1;
        bus.in_bin   = 5'd9;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("midreset");
        push_sweep();
        rst_n = 1'b1;
        wait_ready("midreset_boot");
        chk("midreset_bin9", 64'(mem[9]), 64'd0);
        chk("midreset_count", 64'(sample_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hist_bin_update.md
# hist_bin_update

Histogram update engine that sits directly upstream of the 32-entry dual-address histogram RAM. It accepts a stream of bin indices and performs a pipelined read-modify-write increment of the selected bin, one sample per cycle. It forwards in-flight results so back-to-back hits on the same bin count correctly. It also zero-sweeps the RAM after reset and on request, and keeps a saturating total-sample counter plus a sticky saturation flag for the control register file.

## Interface
- ADDR_W, 5: bin index width; RAM depth is 2**ADDR_W.
- DATA_W, 32: bin counter width.
- RD_LAT, 2: RAM read latency in cycles from address-sampling edge to q valid; must be at least 1.

- clk  in  1  single clock for the block and the RAM.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample bin present.
- in_bin  in  ADDR_W  bin index.
- in_ready  out  1  sample accepted when in_valid && in_ready.
- clear_req  in  1  one-cycle pulse; request zeroing of all bins.
- ram_rdaddress  out  ADDR_W  RAM read address.
- ram_wraddress  out  ADDR_W  RAM write address.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM read data.
- busy  out  1  high while not in RUN.
- sample_count  out  DATA_W  accepted samples since last clear; saturates at all-ones.
- sat_flag  out  1  sticky; set when any bin write saturates.

## Operation
- The FSM has three states:
  - CLEAR: sweep address register clr_addr from 0 to 2**ADDR_W-1; each cycle drives ram_wren=1, ram_wraddress=clr_addr, ram_data=0. After the last address, go to RUN.
  - RUN: in_ready=1. If clear_req=1, go to DRAIN.
  - DRAIN: in_ready=0. Wait until the increment pipeline is empty, then go to CLEAR with clr_addr=0.
- Async reset enters CLEAR with clr_addr=0, empties the pipeline and flushes the forwarding buffer.
- Entering CLEAR, whether from reset or from DRAIN, zeroes sample_count and sat_flag.
- ram_rdaddress = in_bin combinationally in every state. The RAM ignores it except on an accept.
- Increment pipeline:
  - A shift chain of RD_LAT stages holds (valid, bin), advancing every cycle.
  - The sample accepted at edge k reaches writeback during cycle k+RD_LAT.
  - At writeback: ram_wren=1, ram_wraddress=bin, ram_data=sat_inc(base).
- Forwarding buffer:
  - A shift register of RD_LAT entries holds (wvalid, waddr, wdata) of the writes issued in the last RD_LAT cycles, shifted every cycle including idle cycles.
  - base = wdata of the newest valid entry whose waddr equals the writeback bin; otherwise base = ram_q.
  - RAM read-during-write returns old data, so same-cycle writes are covered by the buffer.
- sat_inc(x) = x+1, or all-ones when x is all-ones; in the all-ones case sat_flag is set.
- sample_count increments by 1 per accept, saturating.
- clear_req is ignored in DRAIN and CLEAR. A clear_req in the same cycle as an accept still accepts that sample, and it is written back before CLEAR starts.
- In CLEAR, writeback writes never coincide with sweep writes, because DRAIN guarantees the pipeline is empty.

## Timing
- Reset values:
  - in_ready=0, ram_wren=0, ram_wraddress=0, ram_data=0.
  - busy=1, sample_count=0, sat_flag=0, all pipeline and buffer valids=0.
- After rst_n deasserts, CLEAR lasts 2**ADDR_W cycles (32 by default); in_ready rises on the following cycle.
- Throughput is 1 sample per cycle. Latency from accept edge to the RAM write-commit edge is RD_LAT cycles.
- clear_req at edge c: in_ready=0 from cycle c+1. DRAIN lasts RD_LAT cycles, or fewer if the pipeline is already empty, but is always at least 1 cycle. CLEAR then takes 2**ADDR_W cycles, and RUN resumes.
- sample_count updates on the accept edge. sat_flag updates on the writeback edge.
- Bin counters wrap-protected: never roll over to 0.

## Test plan
- Reset release: ram_wren high for exactly 32 cycles with addresses 0..31 and data 0, then in_ready=1, busy=0, sample_count=0.
- Single sample, bin 3 accepted at edge k: during cycle k+2, ram_wren=1, wraddress=3, data=1; no other writes occur.
- Four back-to-back samples of bin 7 on an empty bin: writes 1,2,3,4 on consecutive cycles; also bins 1,2,1,2 give 1,1,2,2. sample_count ends at 4 in each case.
- RAM model preloaded so that bin 5 holds 0xFFFFFFFE; two back-to-back bin-5 samples: writes 0xFFFFFFFF, then 0xFFFFFFFF, and sat_flag=1 after the second writeback.
- clear_req in the same cycle as the 10th sample of a continuous stream:
  - that sample's write occurs; in_ready is low for at least 1+32 cycles;
  - all bins read 0 afterwards; sample_count=0 and sat_flag=0.
- rst_n asserted mid-stream with 2 samples in flight: no further writeback writes occur, the sweep restarts at 0, and all outputs show their reset values while rst_n is low.
